// File: rtl/median_pkg.sv
// Shared types and constants for the serial 3x3 median filter.
// The sort schedule (4 elimination passes + 4 survivor cycles) is derived from these.
package median_pkg;

    localparam int W            = 8;
    localparam int NB_PIX       = 9;
    localparam int SORT_PASSES  = 4;
    localparam int LATENCY      = 40;
    localparam int FINAL_CYCLES = LATENCY - SORT_PASSES * NB_PIX;
    // After the last pass the survivors sit from this store index upward.
    localparam int TAP          = NB_PIX - SORT_PASSES - 1;

    typedef logic [W-1:0] pixel_t;

    typedef enum logic [1:0] {IDLE, LOAD, SORT, DONE} state_t;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_LOAD,
        OP_FIRST,
        OP_CMP,
        OP_LAST,
        OP_FINAL
    } core_op_t;

endpackage

// File: rtl/median_core.sv
// Median datapath: 9-entry shift store and one compare/exchange unit; max kept, min recirculated.
// One op per clock under control of the top; no backpressure, no internal control state.
module median_core
    import median_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  core_op_t op,
    input  pixel_t   din,
    output pixel_t   median
);

    pixel_t store [NB_PIX];
    pixel_t max_q;
    pixel_t cand;
    pixel_t hi;
    pixel_t lo;
    pixel_t push;
    logic   shift;

    always_comb begin
        cand  = (op == OP_FINAL) ? store[TAP] : store[0];
        hi    = (cand > max_q) ? cand  : max_q;
        lo    = (cand > max_q) ? max_q : cand;
        shift = 1'b1;
        push  = '0;
        case (op)
            OP_LOAD:         push = din;
            OP_FIRST:        push = '0;
            OP_CMP, OP_LAST: push = lo;
            OP_FINAL:        push = store[0];
            default:         shift = 1'b0;
        endcase
    end

    // Only meaningful on the final survivor cycle, where cand is the last survivor.
    assign median = hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NB_PIX; i++) store[i] <= '0;
            max_q <= '0;
        end else begin
            if (shift) begin
                for (int i = 0; i < NB_PIX - 1; i++) store[i] <= store[i+1];
                store[NB_PIX-1] <= push;
            end
            // The last pass hands its survivor (not the discarded max) to the final scan.
            case (op)
                OP_FIRST:          max_q <= store[0];
                OP_CMP, OP_FINAL:  max_q <= hi;
                OP_LAST:           max_q <= lo;
                default:           max_q <= max_q;
            endcase
        end
    end

endmodule

// File: rtl/median_filter.sv
// Serial 3x3 median: 9 samples in on DSI, median out on DO with a one-cycle DSO.
// Fixed 40-edge latency from the 9th sample; no backpressure, samples during SORT/DONE are dropped.
module median_filter
    import median_pkg::*;
(
    input  logic       CLK,
    input  logic       nRST,
    input  logic [7:0] DI,
    input  logic       DSI,
    output logic [7:0] DO,
    output logic       DSO
);

    state_t     state;
    state_t     next_state;
    core_op_t   op;
    logic [3:0] smp_cnt;
    logic [3:0] cyc_cnt;
    logic [2:0] pass_cnt;
    logic       sort_end;
    pixel_t     median;

    median_core u_core (
        .clk    (CLK),
        .rst_n  (nRST),
        .op     (op),
        .din    (DI),
        .median (median)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        op         = OP_HOLD;
        sort_end   = 1'b0;
        case (state)
            IDLE: if (DSI) begin
                op         = OP_LOAD;
                next_state = LOAD;
            end
            LOAD: if (DSI) begin
                op = OP_LOAD;
                if (smp_cnt == 4'(NB_PIX - 1)) next_state = SORT;
            end
            SORT: begin
                if (pass_cnt == 3'(SORT_PASSES)) begin
                    op = OP_FINAL;
                    if (cyc_cnt == 4'(FINAL_CYCLES - 1)) begin
                        sort_end   = 1'b1;
                        next_state = DONE;
                    end
                end else if (cyc_cnt == '0) begin
                    op = OP_FIRST;
                end else if (pass_cnt == 3'(SORT_PASSES - 1) && cyc_cnt == 4'(NB_PIX - 1)) begin
                    op = OP_LAST;
                end else begin
                    op = OP_CMP;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            smp_cnt  <= '0;
            cyc_cnt  <= '0;
            pass_cnt <= '0;
        end else begin
            if (op == OP_LOAD)
                smp_cnt <= (smp_cnt == 4'(NB_PIX - 1)) ? '0 : smp_cnt + 4'd1;
            if (state != SORT) begin
                cyc_cnt  <= '0;
                pass_cnt <= '0;
            end else if (pass_cnt != 3'(SORT_PASSES) && cyc_cnt == 4'(NB_PIX - 1)) begin
                cyc_cnt  <= '0;
                pass_cnt <= pass_cnt + 3'd1;
            end else begin
                cyc_cnt  <= cyc_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            DO  <= '0;
            DSO <= 1'b0;
        end else begin
            DSO <= sort_end;
            if (sort_end) DO <= median;
        end
    end

endmodule

// File: tb/tb_median_filter.sv
// Scoreboard bench for median_filter: driver queues expected median and due edge,
// a negedge monitor checks every DSO pulse, pulse width and DO hold behaviour.
module tb_median_filter;
    import median_pkg::*;

    logic       CLK = 1'b0;
    logic       nRST;
    logic [7:0] DI;
    logic       DSI;
    logic [7:0] DO;
    logic       DSO;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    typedef struct {
        pixel_t med;
        int     due;
    } exp_t;

    exp_t   exp_q [$];
    pixel_t last_do  = '0;
    logic   dso_prev = 1'b0;
    pixel_t win [9];

    median_filter dut (
        .CLK  (CLK),
        .nRST (nRST),
        .DI   (DI),
        .DSI  (DSI),
        .DO   (DO),
        .DSO  (DSO)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) edge_n <= edge_n + 1;

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (DSO === 1'b1) begin
            checks++;
            if (dso_prev) begin
                failures++;
                $display("FAIL dso_width: DSO high on consecutive cycles at edge %0d", edge_n);
            end
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_dso: edge %0d DO=%0d, no window pending", edge_n, DO);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (DO !== e.med) begin
                    failures++;
                    $display("FAIL median: DO=%0d expected %0d", DO, e.med);
                end
                checks++;
                if (edge_n != e.due) begin
                    failures++;
                    $display("FAIL latency: DSO at edge %0d expected edge %0d", edge_n, e.due);
                end
            end
            last_do = DO;
        end else begin
            checks++;
            if (DO !== last_do) begin
                failures++;
                $display("FAIL do_hold: DO=%0d expected held %0d at edge %0d", DO, last_do, edge_n);
            end
        end
        dso_prev = DSO;
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic send(input pixel_t px [9], input int gap_at, input int gap_len, input pixel_t med);
        for (int i = 0; i < 9; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    DSI = 1'b0;
                    DI  = 8'($urandom);
                    tick();
                end
            end
            DSI = 1'b1;
            DI  = px[i];
            if (i == 8) exp_q.push_back('{med: med, due: edge_n + 1 + LATENCY});
            tick();
        end
        DSI = 1'b0;
        DI  = 8'($urandom);
    endtask

    task automatic wait_dso(input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            tick();
            if (DSO === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL dso_timeout: no DSO within %0d cycles", limit);
            exp_q.delete();
        end
        tick();
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (DO !== 8'd0 || DSO !== 1'b0) begin
            failures++;
            $display("FAIL %s: DO=%0d DSO=%0b expected DO=0 DSO=0", name, DO, DSO);
        end
    endtask

    function automatic pixel_t sw_median(input pixel_t px [9]);
        pixel_t a [9];
        pixel_t t;
        a = px;
        for (int i = 1; i < 9; i++) begin
            for (int j = i; j > 0; j--) begin
                if (a[j-1] > a[j]) begin
                    t      = a[j];
                    a[j]   = a[j-1];
                    a[j-1] = t;
                end
            end
        end
        return a[4];
    endfunction

    initial begin
        nRST = 1'b0;
        DSI  = 1'b0;
        DI   = '0;

        for (int i = 0; i < 6; i++) begin
            DI  = 8'($urandom);
            DSI = 1'($urandom_range(0, 1));
            tick();
            check_zero("reset_state");
        end
        DSI  = 1'b0;
        nRST = 1'b1;
        repeat (20) tick();

        win = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        send(win, -1, 0, 8'd5);
        wait_dso(60);
        repeat (10) tick();

        win = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        send(win, -1, 0, 8'd5);
        wait_dso(60);

        win = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        send(win, -1, 0, 8'd255);
        wait_dso(60);

        win = '{8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7};
        send(win, -1, 0, 8'd7);
        wait_dso(60);

        win = '{8'd10, 8'd200, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
        send(win, 5, 3, 8'd60);
        wait_dso(60);

        for (int w = 0; w < 200; w++) begin
            for (int j = 0; j < 9; j++)
                win[j] = (w % 4 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            send(win, -1, 0, sw_median(win));
            wait_dso(60);
        end

        win = '{8'd200, 8'd201, 8'd202, 8'd203, 8'd204, 8'd205, 8'd206, 8'd207, 8'd208};
        send(win, -1, 0, 8'd204);
        repeat (20) tick();
        nRST = 1'b0;
        #1;
        check_zero("reset_abort");
        exp_q.delete();
        last_do = '0;
        repeat (3) tick();
        check_zero("reset_hold");
        nRST = 1'b1;
        repeat (60) tick();

        win = '{8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd2, 8'd6, 8'd5};
        send(win, -1, 0, 8'd4);
        wait_dso(60);
        repeat (5) tick();

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected results never delivered", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
